// File: rtl/bcd_stopwatch_mux.sv
// Stopwatch core: debounced buttons, clock-enable BCD counter and a registered
// common-anode 7-segment multiplexer. Define LAP_FUNCTION_EN for lap hold/clear.
module bcd_stopwatch_mux #(
  parameter int CLK_HZ          = 100000000,
  parameter int TICK_HZ         = 10,
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_HZ      = 1000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  output logic                    running,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    overflow,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);

  localparam int PRE_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int REF_MAX = CLK_HZ / REFRESH_HZ - 1;
  localparam int PRE_W   = (PRE_MAX < 1) ? 1 : $clog2(PRE_MAX + 1);
  localparam int REF_W   = (REF_MAX < 1) ? 1 : $clog2(REF_MAX + 1);
  localparam int DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_W   = 4 * NUM_DIGITS;

  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRE_MAX);
  localparam logic [REF_W-1:0] REF_TOP = REF_W'(REF_MAX);
  localparam logic [DB_W-1:0]  DB_TOP  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_DP  = IDX_W'(1);

`ifdef LAP_FUNCTION_EN
  localparam int NB = 2;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {lap, start_stop};
`else
  localparam int NB = 1;
  logic [NB-1:0] btn_raw;
  logic          unused_lap;
  assign btn_raw    = start_stop;
  assign unused_lap = lap;
`endif

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Button conditioning state
  logic [NB-1:0]           sync1_q, sync2_q;
  logic [NB-1:0]           level_q, level_d, level_prev_q;
  logic [NB-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [NB-1:0]           pulse;
  logic                    ss_pulse;

  // Run control and count chain
  run_state_e       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             carry;

  // Display multiplexer
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [3:0]            sel_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      db_cnt_q     <= db_cnt_d;
    end
  end

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    for (int b = 0; b < NB; b++) begin
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_TOP) begin
          level_d[b] = ~level_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign pulse    = level_q & ~level_prev_q;
  assign ss_pulse = pulse[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    running = 1'b0;
    case (state_q)
      ST_STOPPED: begin
        if (ss_pulse) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        running = 1'b1;
        if (ss_pulse) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Prescaler only advances while running, so a stop keeps the partial interval.
  assign tick = (state_q == ST_RUNNING) && (pre_q == PRE_TOP);

`ifdef LAP_FUNCTION_EN
  logic             lap_pulse;
  logic             hold_q, hold_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  assign lap_pulse = pulse[1];
`endif

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    carry = tick;
    if (state_q == ST_RUNNING) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (cnt_q[4*k +: 4] == 4'd9) begin
          cnt_d[4*k +: 4] = 4'd0;
        end else begin
          cnt_d[4*k +: 4] = cnt_q[4*k +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    if (carry) ovf_d = 1'b1;
`ifdef LAP_FUNCTION_EN
    // Lap decisions use the run state before any same-cycle start/stop toggle.
    hold_d = hold_q;
    if (lap_pulse) begin
      if (hold_q) begin
        hold_d = 1'b0;
      end else if (state_q == ST_RUNNING) begin
        hold_d = 1'b1;
      end else begin
        cnt_d = '0;
        pre_d = '0;
        ovf_d = 1'b0;
      end
    end
    disp_d = hold_d ? disp_q : cnt_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef LAP_FUNCTION_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
      disp_q <= '0;
    end else begin
      hold_q <= hold_d;
      disp_q <= disp_d;
    end
  end

  assign digits = disp_q;
`else
  assign digits = cnt_q;
`endif

  assign overflow = ovf_q;

  always_comb begin
    ref_d     = ref_q + 1'b1;
    idx_d     = idx_q;
    sel_digit = 4'd0;
    an_d      = '1;
    if (ref_q == REF_TOP) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_TOP) ? '0 : idx_q + 1'b1;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_digit = digits[4*k +: 4];
        an_d[k]   = 1'b0;
      end
    end
    seg_d = seg_decode(sel_digit);
    dp_d  = (idx_q != IDX_DP);
  end

  // Segment outputs are registered from the index, so they lag it by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_stopwatch_mux.sv
// Bench for bcd_stopwatch_mux: cycle-stamped expectations are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_bcd_stopwatch_mux;

  localparam int ND       = 4;
  localparam int RST_LAST = 2;

  logic clk = 1'b0;
  logic rst, ss_a, lap_a, ss_b, lap_b;
  logic run_a, ovf_a, dp_a, run_b, ovf_b, dp_b;
  logic [4*ND-1:0] dig_a, dig_b;
  logic [6:0] seg_a, seg_b;
  logic [ND-1:0] an_a, an_b;

  bcd_stopwatch_mux #(
    .CLK_HZ(1000), .TICK_HZ(10), .NUM_DIGITS(ND), .REFRESH_HZ(250), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(rst), .start_stop(ss_a), .lap(lap_a), .running(run_a),
    .digits(dig_a), .overflow(ovf_a), .seg(seg_a), .an(an_a), .dp(dp_a)
  );

  // One tick per running cycle, so large counts are reachable quickly.
  bcd_stopwatch_mux #(
    .CLK_HZ(1000), .TICK_HZ(1000), .NUM_DIGITS(ND), .REFRESH_HZ(250), .DEBOUNCE_CYCLES(4)
  ) dut_fast (
    .clk(clk), .reset(rst), .start_stop(ss_b), .lap(lap_b), .running(run_b),
    .digits(dig_b), .overflow(ovf_b), .seg(seg_b), .an(an_b), .dp(dp_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int kind;
    int exp;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  function automatic int actual(input int kind);
    int v;
    v = 0;
    case (kind)
      0:  v[0]    = run_a;
      1:  v[15:0] = dig_a;
      2:  v[0]    = ovf_a;
      3:  v[3:0]  = an_a;
      4:  v[6:0]  = seg_a;
      5:  v[0]    = dp_a;
      6:  v[0]    = run_b;
      7:  v[15:0] = dig_b;
      8:  v[0]    = ovf_b;
      9:  v[3:0]  = an_b;
      10: v[6:0]  = seg_b;
      11: v[0]    = dp_b;
      default: v = -1;
    endcase
    return v;
  endfunction

  function automatic string kname(input int kind);
    string n;
    case (kind % 6)
      0: n = "running";
      1: n = "digits";
      2: n = "overflow";
      3: n = "an";
      4: n = "seg";
      default: n = "dp";
    endcase
    return (kind >= 6) ? {"fast.", n} : {"main.", n};
  endfunction

  task automatic expect_at(input int at, input int kind, input int exp);
    exp_t e;
    int   i;
    e.at = at; e.kind = kind; e.exp = exp;
    i = 0;
    while (i < sbq.size() && sbq[i].at <= at) i++;
    sbq.insert(i, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e   = sbq.pop_front();
      act = actual(e.kind);
      total++;
      if (e.at != cyc) begin
        bad++;
        $display("FAIL %s: check for cycle %0d reached at cycle %0d", kname(e.kind), e.at, cyc);
      end else if (act != e.exp) begin
        bad++;
        $display("FAIL %s @cycle %0d: got %0h, want %0h", kname(e.kind), cyc, act, e.exp);
      end
    end
    if (done && sbq.size() > 0) begin
      total += sbq.size();
      bad   += sbq.size();
      $display("FAIL scoreboard: %0d expectations never checked", sbq.size());
      sbq.delete();
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int btn, input logic v);
    case (btn)
      0: ss_a  = v;
      1: lap_a = v;
      default: ss_b = v;
    endcase
  endtask

  task automatic press(input int btn, input int len);
    int p;
    p = cyc;
    set_btn(btn, 1'b1);
    wait_to(p + len);
    set_btn(btn, 1'b0);
  endtask

  initial begin
    int p0, q0, y0, s0, f0, v0, r0;
    rst = 1'b1; ss_a = 1'b0; lap_a = 1'b0; ss_b = 1'b0; lap_b = 1'b0;
    p0 = 30; q0 = p0 + 1100; y0 = q0 + 600; s0 = y0 + 100;
    f0 = s0 + 1900; v0 = f0 + 1300; r0 = v0 + 7 + 8810;

    for (int d = 0; d < 2; d++) begin
      expect_at(RST_LAST, 6*d + 0, 0);
      expect_at(RST_LAST, 6*d + 1, 0);
      expect_at(RST_LAST, 6*d + 2, 0);
      expect_at(RST_LAST, 6*d + 3, 'hF);
      expect_at(RST_LAST, 6*d + 4, 'h7F);
      expect_at(RST_LAST, 6*d + 5, 1);
    end
    wait_to(RST_LAST);
    rst = 1'b0;

    // A 2-cycle glitch never reaches the debounced level.
    expect_at(20, 0, 0);
    wait_to(10);
    press(0, 2);

    // Start at p0, stop 1000 cycles later; the final tick coincides with the stop.
    expect_at(p0 + 6, 0, 0);
    expect_at(p0 + 7, 0, 1);
    expect_at(p0 + 1006, 1, 'h0009);
    expect_at(p0 + 1006, 0, 1);
    expect_at(p0 + 1007, 1, 'h0010);
    expect_at(p0 + 1007, 0, 0);
    expect_at(p0 + 1007, 2, 0);
    wait_to(p0);
    press(0, 10);
    wait_to(p0 + 1000);
    press(0, 10);

    // 550 more running cycles leave 50 cycles in the prescaler.
    expect_at(q0 + 560, 1, 'h0015);
    expect_at(q0 + 560, 0, 0);
    wait_to(q0);
    press(0, 10);
    wait_to(q0 + 550);
    press(0, 10);

    expect_at(y0 + 56, 1, 'h0015);
    expect_at(y0 + 57, 1, 'h0016);
    expect_at(y0 + 67, 0, 0);
    wait_to(y0);
    press(0, 10);
    wait_to(y0 + 60);
    press(0, 10);

`ifdef LAP_FUNCTION_EN
    begin
      int t0;
      t0 = s0 + 50;
      expect_at(s0 + 6, 1, 'h0016);
      expect_at(s0 + 7, 1, 'h0000);
      expect_at(t0 + 1206, 1, 'h0011);
      expect_at(t0 + 1207, 1, 'h0012);
      expect_at(t0 + 1307, 1, 'h0012);
      expect_at(t0 + 1600, 1, 'h0012);
      expect_at(t0 + 1600, 0, 1);
      expect_at(t0 + 1736, 1, 'h0012);
      expect_at(t0 + 1737, 1, 'h0017);
      expect_at(t0 + 1757, 0, 0);
      expect_at(t0 + 1776, 1, 'h0017);
      expect_at(t0 + 1777, 1, 'h0000);
      wait_to(s0);
      press(1, 10);
      wait_to(t0);
      press(0, 10);
      wait_to(t0 + 1230);
      press(1, 10);
      wait_to(t0 + 1730);
      press(1, 10);
      wait_to(t0 + 1750);
      press(0, 10);
      wait_to(t0 + 1770);
      press(1, 10);
    end
`else
    expect_at(s0 + 7, 1, 'h0016);
    expect_at(s0 + 30, 1, 'h0016);
    wait_to(s0);
    press(1, 10);
`endif

    // Fast instance: exactly 1234 running cycles give 0x1234, then scan the display.
    expect_at(f0 + 1240, 7, 'h1233);
    expect_at(f0 + 1241, 7, 'h1234);
    expect_at(f0 + 1241, 6, 0);
    for (int c = f0 + 1250; c < f0 + 1266; c++) begin
      int rel, sel;
      rel = c - RST_LAST;
      sel = ((rel - 1) / 4) % 4;
      expect_at(c, 9, 'hF & ~(1 << sel));
      expect_at(c, 10, int'(segtab[4 - sel]));
      expect_at(c, 11, (sel == 1) ? 0 : 1);
    end
    wait_to(f0);
    press(2, 10);
    wait_to(f0 + 1234);
    press(2, 10);

    // Resume from 1234 through the all-9s wrap.
    expect_at(v0 + 7 + 766, 7, 'h2000);
    expect_at(v0 + 7 + 8765, 7, 'h9999);
    expect_at(v0 + 7 + 8765, 8, 0);
    expect_at(v0 + 7 + 8766, 7, 'h0000);
    expect_at(v0 + 7 + 8766, 8, 1);
    expect_at(v0 + 7 + 8800, 7, 'h0034);
    expect_at(v0 + 7 + 8800, 8, 1);
    wait_to(v0);
    press(2, 10);

    expect_at(r0 + 1, 8, 0);
    expect_at(r0 + 1, 7, 0);
    expect_at(r0 + 1, 6, 0);
    expect_at(r0 + 1, 9, 'hF);
    expect_at(r0 + 1, 10, 'h7F);
    expect_at(r0 + 1, 1, 0);
    expect_at(r0 + 1, 2, 0);
    wait_to(r0);
    rst = 1'b1;
    wait_to(r0 + 1);
    rst = 1'b0;

    wait_to(r0 + 4);
    done = 1'b1;
    wait_to(r0 + 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_mux.md
# bcd_stopwatch_mux

Single-clock, parametrised stopwatch core that replaces derived-clock counting with clock-enable ticks. It debounces the start/stop and lap buttons, runs an N-digit BCD counter, and time-multiplexes the result onto a common-anode seven-segment display. It sits directly under the board top level, between the raw button pins and the seg/an pins, and needs no other clock source.

## Interface
- CLK_HZ, 100000000, input clock frequency in Hz
- TICK_HZ, 10, count resolution in Hz (10 gives tenths of a second)
- NUM_DIGITS, 4, number of BCD digits; digit 0 is least significant, NUM_DIGITS >= 2
- REFRESH_HZ, 1000, per-digit display refresh rate in Hz
- DEBOUNCE_CYCLES, 1000000, number of clk cycles a button must be stable to be accepted
- clk  in  1  system clock; one clock; all logic on posedge clk
- reset  in  1  synchronous, active-high; clears all state
- start_stop  in  1  raw asynchronous button; a debounced rising edge toggles run/stop
- lap  in  1  raw asynchronous button; lap/clear function (see Configuration)
- running  out  1  1 while counting
- digits  out  4*NUM_DIGITS  displayed BCD value; digit k is digits[4k+3:4k]
- overflow  out  1  sticky; set when the counter wraps from all-9s
- seg  out  7  {a,b,c,d,e,f,g}, active-low
- an  out  NUM_DIGITS  digit enables, active-low, one-cold
- dp  out  1  decimal point, active-low

## Operation
- **Buttons:** each button passes through a 2-FF synchroniser, then a stability counter. The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. A rising edge of the debounced level gives a 1-cycle pulse.
- **Run control:** a start_stop pulse toggles running.
- **Prescaler:** counts 0..CLK_HZ/TICK_HZ-1 only while running. It holds its value when stopped, so the fractional interval is preserved. At the terminal count it wraps to 0 and issues a 1-cycle tick.
- **Counter:** a tick increments the BCD chain. Each digit counts 0..9 and carries into the next digit when it wraps from 9.
- **Overflow:** when all digits are 9, a tick wraps the chain to all-0 and sets overflow. Overflow stays set until reset.
- **Display mux:**
  - The refresh counter counts 0..CLK_HZ/REFRESH_HZ-1. At wrap, the digit index advances from 0 to NUM_DIGITS-1, then back to 0.
  - an drives low only the bit of the selected digit. seg is the decode of that digit.
  - BCD values 10..15 drive seg to 1111111 (blank).
  - dp is 0 only while digit 1 is selected, which separates seconds from tenths.
- **Decode (seg):** 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- **Reset values:**
  - running=0, overflow=0, digits=0.
  - Prescaler, refresh counter, digit index and lap hold are all 0.
  - Debounced levels are 0.
  - an all 1s, seg=1111111, dp=1.
- **Simultaneous events:**
  - A start_stop pulse in the same cycle as a tick: the tick is counted.
  - start_stop and lap pulses in the same cycle: lap is evaluated against running as it was before the toggle.
  - reset overrides everything, including mid-debounce and mid-tick.

## Timing
- Button to action latency: 2 sync cycles, then DEBOUNCE_CYCLES, then 1 edge-detect cycle. running changes on the following edge.
- From running=1 to the first tick: CLK_HZ/TICK_HZ cycles, from a cleared prescaler.
- digits updates on the cycle after a tick, and is registered.
- an, seg and dp are registered. They change 1 cycle after the digit index advances and are glitch-free between refreshes.

## Configuration
- **LAP_FUNCTION_EN defined:**
  - A lap pulse while running and not held freezes digits (lap hold); counting continues internally.
  - A lap pulse while held releases the hold, and digits shows the live count again.
  - A lap pulse while stopped and not held clears the counter, prescaler and overflow to 0.
- **LAP_FUNCTION_EN undefined:** the lap port is present but ignored, no lap-hold logic is built, and digits always shows the live count.

## Test plan
Simulation parameters: CLK_HZ=1000, TICK_HZ=10, REFRESH_HZ=250, DEBOUNCE_CYCLES=4, NUM_DIGITS=4.
- **Reset:** assert reset for 2 cycles -> running=0, digits=0, overflow=0, an=1111, seg=1111111, dp=1.
- **Debounce:** 2-cycle glitch on start_stop -> running remains 0. Hold start_stop high 10 cycles -> running=1 exactly 2+4+1 cycles after the rising edge.
- **Counting:** run for 1000 cycles, then stop -> digits=0x0010 (1.0 s). Run 550 more cycles -> digits=0x0015, prescaler preserves the remaining 50 cycles.
- **Overflow:** preset the counter to 0x9999, issue one tick -> digits=0x0000 and overflow=1. overflow stays 1 until reset.
- **Display:** digits=0x1234 -> an cycles 1110, 1101, 1011, 0111, each held 4 cycles. seg follows decode of 4, 3, 2, 1. dp=0 only while an=1101.
- **Lap (LAP_FUNCTION_EN):**
  - lap pulse at 0x0012 while running -> digits holds 0x0012 while counting continues.
  - Second lap pulse after 500 cycles -> digits=0x0017.
  - Stop, then lap -> digits=0x0000.
